// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM decode and issue stage: one registered output slot feeding the ALU.
// Optional macro ALU_ISSUE_WB_BYPASS_EN adds a writeback bypass onto the operand reads.
module alu_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
`ifdef ALU_ISSUE_WB_BYPASS_EN
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
`endif
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [2:0]       ex_fn,
    output logic [6:0]       ex_funct7,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [4:0]       ex_rd,
    output logic             illegal
);

    typedef enum logic [2:0] {
        ADD_SUB = 3'd0,
        SLL     = 3'd1,
        SLT     = 3'd2,
        SLTU    = 3'd3,
        XOR     = 3'd4,
        SRL_SRA = 3'd5,
        OR      = 3'd6,
        AND     = 3'd7
    } ALU_FN_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [6:0] opcode_p0;
    logic [2:0] f3_p0;
    logic [6:0] f7_in_p0;

    logic signed [11:0]      imm_p0;
    logic signed [WIDTH-1:0] imm_sx_p0;
    logic [WIDTH-1:0]        shamt_p0;
    logic [WIDTH-1:0]        rs1v_p0;
    logic [WIDTH-1:0]        rs2v_p0;

    ALU_FN_t          fn_p0;
    logic [6:0]       f7_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             legal_p0;
    logic             acc_p0;

    logic             vld_p1;
    logic             ill_p1;
    ALU_FN_t          fn_p1;
    logic [6:0]       f7_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [4:0]       rd_p1;

    // ---- p0: field extraction, operand read, decode ----
    assign opcode_p0 = in_instr[6:0];
    assign f3_p0     = in_instr[14:12];
    assign f7_in_p0  = in_instr[31:25];
    assign rs1_addr  = in_instr[19:15];
    assign rs2_addr  = in_instr[24:20];

    assign imm_p0    = $signed(in_instr[31:20]);
    assign imm_sx_p0 = WIDTH'(imm_p0);
    assign shamt_p0  = WIDTH'(in_instr[24:20]);

    assign in_ready  = !vld_p1 || ex_ready;
    assign acc_p0    = in_valid && in_ready && !flush;

    always_comb begin
        rs1v_p0 = rs1_data;
        rs2v_p0 = rs2_data;
`ifdef ALU_ISSUE_WB_BYPASS_EN
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) rs1v_p0 = wb_data;
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) rs2v_p0 = wb_data;
`endif
        // x0 reads as zero regardless of the register file or any bypass
        if (rs1_addr == 5'd0) rs1v_p0 = '0;
        if (rs2_addr == 5'd0) rs2v_p0 = '0;
    end

    always_comb begin
        fn_p0    = ALU_FN_t'(f3_p0);
        f7_p0    = F7_ZERO;
        a_p0     = rs1v_p0;
        b_p0     = rs2v_p0;
        legal_p0 = 1'b0;
        case (opcode_p0)
            OPC_OP: begin
                f7_p0    = f7_in_p0;
                legal_p0 = (f7_in_p0 == F7_ZERO) ||
                           ((f7_in_p0 == F7_ALT) && ((f3_p0 == 3'b000) || (f3_p0 == 3'b101)));
            end
            OPC_OPIMM: begin
                b_p0     = WIDTH'(imm_sx_p0);
                legal_p0 = 1'b1;
                if (f3_p0 == 3'b001) begin
                    b_p0     = shamt_p0;
                    legal_p0 = (f7_in_p0 == F7_ZERO);
                end else if (f3_p0 == 3'b101) begin
                    b_p0     = shamt_p0;
                    f7_p0    = f7_in_p0;
                    legal_p0 = (f7_in_p0 == F7_ZERO) || (f7_in_p0 == F7_ALT);
                end
            end
            default: legal_p0 = 1'b0;
        endcase
    end

    // ---- p1: output slot ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            ill_p1 <= 1'b0;
            fn_p1  <= ADD_SUB;
            f7_p1  <= '0;
            a_p1   <= '0;
            b_p1   <= '0;
            rd_p1  <= '0;
        end else begin
            ill_p1 <= acc_p0 && !legal_p0;
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (acc_p0 && legal_p0) begin
                vld_p1 <= 1'b1;
                fn_p1  <= fn_p0;
                f7_p1  <= f7_p0;
                a_p1   <= a_p0;
                b_p1   <= b_p0;
                rd_p1  <= in_instr[11:7];
            end else if (ex_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign ex_valid  = vld_p1;
    assign illegal   = ill_p1;
    assign ex_fn     = fn_p1;
    assign ex_funct7 = f7_p1;
    assign ex_a      = a_p1;
    assign ex_b      = b_p1;
    assign ex_rd     = rd_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus a randomized run against a queue-based slot model.
module tb_alu_issue_stage;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic [W-1:0]  rs1_data;
    logic [W-1:0]  rs2_data;
    logic          ex_valid;
    logic          ex_ready;
    logic [2:0]    ex_fn;
    logic [6:0]    ex_funct7;
    logic [W-1:0]  ex_a;
    logic [W-1:0]  ex_b;
    logic [4:0]    ex_rd;
    logic          illegal;
`ifdef ALU_ISSUE_WB_BYPASS_EN
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [W-1:0]  wb_data;
`endif

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [2:0]  fn;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } slot_t;

    wire [79:0] obs = {ex_valid, ex_fn, ex_funct7, ex_a, ex_b, ex_rd};

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef ALU_ISSUE_WB_BYPASS_EN
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_fn(ex_fn),
        .ex_funct7(ex_funct7), .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd),
        .illegal(illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush    = 1'b0;
        in_valid = 1'b0;
        ex_ready = 1'b1;
        in_instr = 32'h0;
        rs1_data = '0;
        rs2_data = '0;
`ifdef ALU_ISSUE_WB_BYPASS_EN
        wb_valid = 1'b0;
        wb_rd    = 5'd0;
        wb_data  = '0;
`endif
    endtask

    // Reference decode taken straight from the instruction-set rules
    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] d1,
                                       input logic [31:0] d2, output logic legal,
                                       output slot_t s);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ins[31:25];
        f3 = ins[14:12];
        s.fn = f3;
        s.rd = ins[11:7];
        s.a  = (ins[19:15] == 5'd0) ? 32'd0 : d1;
        s.b  = 32'd0;
        s.f7 = 7'd0;
        legal = 1'b0;
        if (ins[6:0] == 7'b0110011) begin
            s.b  = (ins[24:20] == 5'd0) ? 32'd0 : d2;
            s.f7 = f7;
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end else if (ins[6:0] == 7'b0010011) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                s.b  = {27'd0, ins[24:20]};
                s.f7 = f7;
                legal = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
            end else begin
                s.b  = 32'($signed(ins) >>> 20);
                legal = 1'b1;
            end
        end
    endfunction

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0] op;
        logic [6:0] f7;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: op = 7'b0110011;
            4, 5, 6, 7: op = 7'b0010011;
            8:          op = 7'b1101111;
            default:    op = 7'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0, 1, 2: f7 = 7'h00;
            3:       f7 = 7'h20;
            4:       f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, pick_reg(), pick_reg(), 3'($urandom), pick_reg(), op};
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        nvec++;
        if (obs !== 80'd0) begin
            nerr++;
            $display("FAIL reset_slot got %h want 0", obs);
        end
        nvec++;
        if (illegal !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_ctl illegal=%b in_ready=%b want 0/1", illegal, in_ready);
        end
        rst_n = 1'b1;
        tick();
        // load a slot, then pull reset asynchronously in the middle of the cycle
        in_valid = 1'b1; ex_ready = 1'b0; in_instr = 32'h002081B3;
        rs1_data = 32'd5; rs2_data = 32'd7;
        tick();
        in_valid = 1'b0;
        nvec++;
        if (ex_valid !== 1'b1) begin
            nerr++;
            $display("FAIL reset_preload ex_valid=%b want 1", ex_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if (obs !== 80'd0) begin
            nerr++;
            $display("FAIL reset_async got %h want 0", obs);
        end
        tick();
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_add();
        logic [79:0] exp;
        in_valid = 1'b1; ex_ready = 1'b1; in_instr = 32'h002081B3;
        rs1_data = 32'd5; rs2_data = 32'd7;
        #1;
        nvec++;
        if ({rs1_addr, rs2_addr, in_ready} !== {5'd1, 5'd2, 1'b1}) begin
            nerr++;
            $display("FAIL add_addr rs1=%0d rs2=%0d rdy=%b want 1 2 1", rs1_addr, rs2_addr, in_ready);
        end
        tick();
        in_valid = 1'b0;
        exp = {1'b1, 3'd0, 7'h00, 32'd5, 32'd7, 5'd3};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL add got %h want %h", obs, exp);
        end
        tick();
        nvec++;
        if (ex_valid !== 1'b0) begin
            nerr++;
            $display("FAIL add_drain ex_valid=%b want 0", ex_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [79:0] exp;
        in_valid = 1'b1; ex_ready = 1'b1; in_instr = 32'h402081B3;
        rs1_data = 32'd10; rs2_data = 32'd3;
        tick();
        in_instr = 32'h4030D213; rs1_data = 32'h80000000; rs2_data = 32'h12345678;
        exp = {1'b1, 3'd0, 7'h20, 32'd10, 32'd3, 5'd3};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL b2b_sub got %h want %h", obs, exp);
        end
        tick();
        in_valid = 1'b0;
        exp = {1'b1, 3'd5, 7'h20, 32'h80000000, 32'd3, 5'd4};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL b2b_srai got %h want %h", obs, exp);
        end
        tick();
    endtask

    task automatic test_addi();
        logic [79:0] exp;
        in_valid = 1'b1; ex_ready = 1'b1; in_instr = 32'hFFF00293;
        rs1_data = 32'hDEAD; rs2_data = 32'hBEEF;
        tick();
        in_valid = 1'b0;
        exp = {1'b1, 3'd0, 7'h00, 32'd0, 32'hFFFFFFFF, 5'd5};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL addi got %h want %h", obs, exp);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [79:0] exp;
        in_valid = 1'b1; ex_ready = 1'b0; in_instr = 32'h002081B3;
        rs1_data = 32'd5; rs2_data = 32'd7;
        tick();
        in_instr = 32'h0020C333; rs1_data = 32'h11; rs2_data = 32'h22;
        exp = {1'b1, 3'd0, 7'h00, 32'd5, 32'd7, 5'd3};
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (in_ready !== 1'b0) begin
                nerr++;
                $display("FAIL bp_ready cyc %0d in_ready=%b want 0", i, in_ready);
            end
            tick();
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL bp_hold cyc %0d got %h want %h", i, obs, exp);
            end
        end
        ex_ready = 1'b1;
        #1;
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL bp_release in_ready=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        exp = {1'b1, 3'd4, 7'h00, 32'h11, 32'h22, 5'd6};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL bp_issue got %h want %h", obs, exp);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad[0] = 32'h0000006F;
        bad[1] = 32'h022081B3;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; ex_ready = 1'b1; in_instr = bad[i];
            rs1_data = 32'd1; rs2_data = 32'd2;
            tick();
            in_valid = 1'b0;
            nvec++;
            if ({illegal, ex_valid} !== 2'b10) begin
                nerr++;
                $display("FAIL illegal_%0d illegal=%b ex_valid=%b want 1/0", i, illegal, ex_valid);
            end
            tick();
            nvec++;
            if (illegal !== 1'b0) begin
                nerr++;
                $display("FAIL illegal_pulse_%0d illegal=%b want 0", i, illegal);
            end
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; ex_ready = 1'b0; in_instr = 32'h002081B3;
        rs1_data = 32'd5; rs2_data = 32'd7;
        tick();
        flush = 1'b1; ex_ready = 1'b1; in_instr = 32'h0020C333;
        tick();
        nvec++;
        if ({ex_valid, illegal} !== 2'b00) begin
            nerr++;
            $display("FAIL flush_slot ex_valid=%b illegal=%b want 0/0", ex_valid, illegal);
        end
        in_instr = 32'h0000006F;
        tick();
        nvec++;
        if ({ex_valid, illegal} !== 2'b00) begin
            nerr++;
            $display("FAIL flush_illegal ex_valid=%b illegal=%b want 0/0", ex_valid, illegal);
        end
        idle_inputs();
        tick();
    endtask

`ifdef ALU_ISSUE_WB_BYPASS_EN
    task automatic test_bypass();
        in_valid = 1'b1; ex_ready = 1'b1; in_instr = 32'h002081B3;
        rs1_data = 32'd5; rs2_data = 32'd7;
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
        tick();
        nvec++;
        if ({ex_a, ex_b} !== {32'd9, 32'd7}) begin
            nerr++;
            $display("FAIL bypass_hit a=%h b=%h want 9 7", ex_a, ex_b);
        end
        wb_rd = 5'd0;
        tick();
        nvec++;
        if ({ex_a, ex_b} !== {32'd5, 32'd7}) begin
            nerr++;
            $display("FAIL bypass_x0 a=%h b=%h want 5 7", ex_a, ex_b);
        end
        idle_inputs();
        tick();
    endtask
`endif

    task automatic test_random();
        slot_t q[$];
        slot_t s;
        logic  legal;
        logic  exp_rdy;
        logic  acc;
        logic  exp_ill;
        exp_ill = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            in_instr = gen_instr();
            rs1_data = $urandom;
            rs2_data = $urandom;
            #1;
            exp_rdy = (q.size() == 0) || ex_ready;
            nvec++;
            if ({in_ready, rs1_addr, rs2_addr} !== {exp_rdy, in_instr[19:15], in_instr[24:20]}) begin
                nerr++;
                $display("FAIL rnd_ready cyc %0d got %b/%0d/%0d want %b/%0d/%0d", cyc,
                         in_ready, rs1_addr, rs2_addr, exp_rdy, in_instr[19:15], in_instr[24:20]);
            end
            acc = in_valid && exp_rdy && !flush;
            ref_decode(in_instr, rs1_data, rs2_data, legal, s);
            tick();
            if (flush) begin
                q.delete();
            end else begin
                if (ex_ready && q.size() != 0) void'(q.pop_front());
                if (acc && legal) q.push_back(s);
            end
            exp_ill = acc && !legal;
            nvec++;
            if ({ex_valid, illegal} !== {(q.size() != 0), exp_ill}) begin
                nerr++;
                $display("FAIL rnd_ctl cyc %0d valid/illegal=%b%b want %b%b", cyc,
                         ex_valid, illegal, (q.size() != 0), exp_ill);
            end
            if (q.size() != 0) begin
                nvec++;
                if ({ex_fn, ex_funct7, ex_a, ex_b, ex_rd} !== q[0]) begin
                    nerr++;
                    $display("FAIL rnd_slot cyc %0d got %h want %h", cyc,
                             {ex_fn, ex_funct7, ex_a, ex_b, ex_rd}, q[0]);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_add();
        test_back_to_back();
        test_addi();
        test_backpressure();
        test_illegal();
        test_flush();
`ifdef ALU_ISSUE_WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
